pht_port_scheduler: RTL and testbench

- Owns the single read/write port of a 2-bit-counter pattern history table (PHT) SRAM.
- Shares the port between decode-stage prediction reads and EX-stage feedback updates. Updates are read-modify-write operations queued in a small FIFO.
- After reset, sequences an initialisation sweep that writes every PHT entry to weakly-not-taken.
- Sits between the branch controller and an external PHT memory macro, which has no reset and a 1-cycle read latency.

---
 rtl/mips_core_pkg.sv | 29 ++
 rtl/pht_update_fifo.sv | 61 ++++++
 rtl/pht_port_scheduler.sv | 138 +++++++++++++
 tb/tb_pht_port_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome encoding plus PHT port-scheduler state and constants.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef enum logic [1:0] {
        PHT_INIT,
        PHT_IDLE,
        PHT_RD_WAIT,
        PHT_WR_PEND
    } PhtSchedState;

    localparam logic [1:0] PHT_COUNTER_INIT = 2'b01;

    // Saturating 2-bit counter step; saturated values are still returned for writing.
    function automatic logic [1:0] pht_next_counter(input logic [1:0] cnt, input BranchOutcome outcome);
        if (outcome == TAKEN)
            return (cnt == 2'b11) ? 2'b11 : cnt + 2'd1;
        return (cnt == 2'b00) ? 2'b00 : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/pht_update_fifo.sv
// Small FIFO of pending PHT updates ({index, outcome}); head is presented combinationally.
module pht_update_fifo
    import mips_core_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int FB_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [INDEX_BITS-1:0] i_push_index,
    input  BranchOutcome          i_push_outcome,
    input  logic                  i_pop,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [INDEX_BITS-1:0] o_head_index,
    output BranchOutcome          o_head_outcome
);

    localparam int PTR_BITS = $clog2(FB_DEPTH);

    logic [INDEX_BITS-1:0] r_idx [FB_DEPTH];
    BranchOutcome          r_out [FB_DEPTH];
    logic [PTR_BITS-1:0]   r_wptr;
    logic [PTR_BITS-1:0]   r_rptr;
    logic [PTR_BITS:0]     r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_full         = (r_count == (PTR_BITS+1)'(FB_DEPTH));
    assign o_empty        = (r_count == '0);
    assign w_push         = i_push && !o_full;
    assign w_pop          = i_pop && !o_empty;
    assign o_head_index   = r_idx[r_rptr];
    assign o_head_outcome = r_out[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_idx[r_wptr] <= i_push_index;
            r_out[r_wptr] <= i_push_outcome;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/pht_port_scheduler.sv
// Arbitrates the single PHT SRAM port between prediction reads, queued read-modify-write
// updates and the post-reset initialisation sweep.
module pht_port_scheduler
    import mips_core_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int FB_DEPTH   = 4,
    parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_pc,
    output logic                  o_req_ready,
    output logic                  o_pred_valid,
    output BranchOutcome          o_pred,
    input  logic                  i_fb_valid,
    input  logic [ADDR_WIDTH-1:0] i_fb_pc,
    input  BranchOutcome          i_fb_outcome,
    output logic                  o_fb_ready,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [INDEX_BITS-1:0] mem_addr,
    output logic [1:0]            mem_wdata,
    input  logic [1:0]            mem_rdata
);

    PhtSchedState          r_state;
    PhtSchedState          w_next_state;
    logic [INDEX_BITS-1:0] r_sweep;
    logic [1:0]            r_wval;
    logic                  r_pred_valid;

    logic                  w_full;
    logic                  w_empty;
    logic [INDEX_BITS-1:0] w_head_index;
    BranchOutcome          w_head_outcome;
    logic [INDEX_BITS-1:0] w_req_index;
    logic [INDEX_BITS-1:0] w_fb_index;
    logic                  w_pred_win;
    logic                  w_upd_wr;
    logic                  w_upd_rd;
    logic                  w_push;
    logic [1:0]            w_new_cnt;
    logic                  w_unused;

    assign w_req_index = i_req_pc[INDEX_BITS+1:2];
    assign w_fb_index  = i_fb_pc[INDEX_BITS+1:2];
    assign w_unused    = ^{i_req_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_req_pc[1:0],
                           i_fb_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_fb_pc[1:0]};

    // A full queue blocks predictions so the pending update always drains.
    assign w_pred_win = (r_state != PHT_INIT) && i_req_valid && !w_full;
    assign w_upd_wr   = !w_pred_win && ((r_state == PHT_RD_WAIT) || (r_state == PHT_WR_PEND));
    assign w_upd_rd   = !w_pred_win && (r_state == PHT_IDLE) && !w_empty;
    assign w_new_cnt  = pht_next_counter(mem_rdata, w_head_outcome);

    assign o_fb_ready   = !rst && (r_state != PHT_INIT) && !w_full;
    assign o_req_ready  = w_pred_win;
    assign w_push       = i_fb_valid && o_fb_ready;
    assign o_pred_valid = r_pred_valid;
    assign o_pred       = (r_pred_valid && mem_rdata[1]) ? TAKEN : NOT_TAKEN;

    pht_update_fifo #(
        .INDEX_BITS(INDEX_BITS),
        .FB_DEPTH  (FB_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .i_push        (w_push),
        .i_push_index  (w_fb_index),
        .i_push_outcome(i_fb_outcome),
        .i_pop         (w_upd_wr),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_head_index  (w_head_index),
        .o_head_outcome(w_head_outcome)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= PHT_INIT;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            PHT_INIT:    if (r_sweep == '1) w_next_state = PHT_IDLE;
            PHT_IDLE:    if (w_upd_rd) w_next_state = PHT_RD_WAIT;
            PHT_RD_WAIT: w_next_state = w_upd_wr ? PHT_IDLE : PHT_WR_PEND;
            PHT_WR_PEND: if (w_upd_wr) w_next_state = PHT_IDLE;
            default:     w_next_state = PHT_INIT;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (r_state == PHT_INIT) begin
            if (!rst) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_sweep;
                mem_wdata = PHT_COUNTER_INIT;
            end
        end else if (w_pred_win) begin
            mem_en   = 1'b1;
            mem_addr = w_req_index;
        end else if (w_upd_wr) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = w_head_index;
            mem_wdata = (r_state == PHT_RD_WAIT) ? w_new_cnt : r_wval;
        end else if (w_upd_rd) begin
            mem_en   = 1'b1;
            mem_addr = w_head_index;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sweep      <= '0;
            r_wval       <= '0;
            r_pred_valid <= 1'b0;
        end else begin
            r_pred_valid <= w_pred_win;
            if (r_state == PHT_INIT)
                r_sweep <= r_sweep + 1'b1;
            if ((r_state == PHT_RD_WAIT) && !w_upd_wr)
                r_wval <= w_new_cnt;
        end
    end

endmodule

// File: tb/tb_pht_port_scheduler.sv
// Directed bench for pht_port_scheduler with a behavioural 1-cycle-latency PHT SRAM.
module tb_pht_port_scheduler;
    import mips_core_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_req_valid = 1'b0;
    logic [31:0]  i_req_pc = '0;
    logic         o_req_ready;
    logic         o_pred_valid;
    BranchOutcome o_pred;
    logic         i_fb_valid = 1'b0;
    logic [31:0]  i_fb_pc = '0;
    BranchOutcome i_fb_outcome = NOT_TAKEN;
    logic         o_fb_ready;
    logic         mem_en;
    logic         mem_we;
    logic [3:0]   mem_addr;
    logic [1:0]   mem_wdata;
    logic [1:0]   mem_rdata = '0;
    logic [1:0]   pht [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pht_port_scheduler #(
        .INDEX_BITS(4),
        .FB_DEPTH  (4),
        .ADDR_WIDTH(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .i_req_pc    (i_req_pc),
        .o_req_ready (o_req_ready),
        .o_pred_valid(o_pred_valid),
        .o_pred      (o_pred),
        .i_fb_valid  (i_fb_valid),
        .i_fb_pc     (i_fb_pc),
        .i_fb_outcome(i_fb_outcome),
        .o_fb_ready  (o_fb_ready),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) pht[mem_addr] <= mem_wdata;
            else        mem_rdata <= pht[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc,
                         input logic fv, input logic [31:0] fpc, input BranchOutcome fo);
        @(negedge clk);
        i_req_valid  = rv;
        i_req_pc     = rpc;
        i_fb_valid   = fv;
        i_fb_pc      = fpc;
        i_fb_outcome = fo;
        #1;
    endtask

    task automatic check_write(input string tag, input logic [3:0] addr, input logic [1:0] data);
        check({tag, "_en"}, 32'(mem_en), 32'd1);
        check({tag, "_we"}, 32'(mem_we), 32'd1);
        check({tag, "_addr"}, 32'(mem_addr), 32'(addr));
        check({tag, "_wdata"}, 32'(mem_wdata), 32'(data));
    endtask

    task automatic check_read(input string tag, input logic [3:0] addr);
        check({tag, "_en"}, 32'(mem_en), 32'd1);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'(addr));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"}, 32'(mem_en), 32'd0);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_req_rdy"}, 32'(o_req_ready), 32'd0);
        check({tag, "_fb_rdy"}, 32'(o_fb_ready), 32'd0);
        check({tag, "_pvalid"}, 32'(o_pred_valid), 32'd0);
        check({tag, "_pred"}, 32'(o_pred), 32'd0);
    endtask

    task automatic init_sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) drive(1'b1, 32'h40, 1'b0, 32'h0, NOT_TAKEN);
            check_write(tag, 4'(i), 2'b01);
            check({tag, "_req_rdy"}, 32'(o_req_ready), 32'd0);
            check({tag, "_fb_rdy"}, 32'(o_fb_ready), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state with a request pending: nothing may drive the port.
        drive(1'b1, 32'h40, 1'b1, 32'h44, TAKEN);
        check_all_zero("rst");

        // 1. Sweep, then first prediction of a freshly initialised entry.
        @(negedge clk);
        rst = 1'b0;
        #1;
        init_sweep("sweep");
        drive(1'b1, 32'h40, 1'b0, 32'h0, NOT_TAKEN);
        check("t1_req_rdy", 32'(o_req_ready), 32'd1);
        check_read("t1_pred_rd", 4'd0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, NOT_TAKEN);
        check("t1_pvalid", 32'(o_pred_valid), 32'd1);
        check("t1_pred", 32'(o_pred), 32'(NOT_TAKEN));

        // 2. Two TAKEN updates on index 1: 01 -> 10 -> 11.
        drive(1'b0, 32'h0, 1'b1, 32'h44, TAKEN);
        check("t2_fb_rdy", 32'(o_fb_ready), 32'd1);
        check("t2_pvalid_low", 32'(o_pred_valid), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 32'h44, TAKEN);
        check_read("t2_rd0", 4'd1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, NOT_TAKEN);
        check("t2_pvalid_after_upd_rd", 32'(o_pred_valid), 32'd0);
        check_write("t2_wr0", 4'd1, 2'b10);
        drive(1'b0, 32'h0, 1'b0, 32'h0, NOT_TAKEN);
        check_read("t2_rd1", 4'd1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, NOT_TAKEN);
        check_write("t2_wr1", 4'd1, 2'b11);
        drive(1'b1, 32'h44, 1'b0, 32'h0, NOT_TAKEN);
        check_read("t2_pred_rd", 4'd1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, NOT_TAKEN);
        check("t2_pvalid", 32'(o_pred_valid), 32'd1);
        check("t2_pred", 32'(o_pred), 32'(TAKEN));

        // 3. Three NOT_TAKEN on index 2: 01 -> 00 -> 00 -> 00, every one written.
        drive(1'b0, 32'h0, 1'b1, 32'h48, NOT_TAKEN);
        drive(1'b0, 32'h0, 1'b1, 32'h48, NOT_TAKEN);
        check_read("t3_rd0", 4'd2);
        drive(1'b0, 32'h0, 1'b1, 32'h48, NOT_TAKEN);
        check_write("t3_wr0", 4'd2, 2'b00);
        for (int k = 1; k < 3; k++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, NOT_TAKEN);
            check_read("t3_rd", 4'd2);
            drive(1'b0, 32'h0, 1'b0, 32'h0, NOT_TAKEN);
            check_write("t3_wr", 4'd2, 2'b00);
        end
        drive(1'b1, 32'h48, 1'b0, 32'h0, NOT_TAKEN);
        drive(1'b0, 32'h0, 1'b0, 32'h0, NOT_TAKEN);
        check("t3_pvalid", 32'(o_pred_valid), 32'd1);
        check("t3_pred", 32'(o_pred), 32'(NOT_TAKEN));

        // 4. Requests held high while four TAKEN feedbacks on index 3 fill the queue.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h40, 1'b1, 32'h4C, TAKEN);
            check("t4_fb_rdy", 32'(o_fb_ready), 32'd1);
            check("t4_req_rdy", 32'(o_req_ready), 32'd1);
            if (k > 0) check("t4_pvalid", 32'(o_pred_valid), 32'd1);
        end
        drive(1'b1, 32'h40, 1'b0, 32'h0, NOT_TAKEN);
        check("t4_full_fb_rdy", 32'(o_fb_ready), 32'd0);
        check("t4_full_req_rdy", 32'(o_req_ready), 32'd0);
        check_read("t4_upd_rd", 4'd3);
        drive(1'b1, 32'h40, 1'b0, 32'h0, NOT_TAKEN);
        check("t4_wr_req_rdy", 32'(o_req_ready), 32'd0);
        check("t4_wr_pvalid", 32'(o_pred_valid), 32'd0);
        check_write("t4_upd_wr", 4'd3, 2'b10);
        drive(1'b1, 32'h40, 1'b0, 32'h0, NOT_TAKEN);
        check("t4_req_rdy_back", 32'(o_req_ready), 32'd1);
        check("t4_fb_rdy_back", 32'(o_fb_ready), 32'd1);
        check_read("t4_pred_rd", 4'd0);
        for (int k = 0; k < 8; k++) drive(1'b0, 32'h0, 1'b0, 32'h0, NOT_TAKEN);
        check("t4_idle_en", 32'(mem_en), 32'd0);
        check("t4_pht3", 32'(pht[3]), 32'd3);

        // 5. Prediction steals the port after an update read: WR_PEND then late write.
        drive(1'b0, 32'h0, 1'b1, 32'h50, TAKEN);
        check("t5_idle_en", 32'(mem_en), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, NOT_TAKEN);
        check_read("t5_upd_rd", 4'd4);
        drive(1'b1, 32'h40, 1'b0, 32'h0, NOT_TAKEN);
        check("t5_req_rdy", 32'(o_req_ready), 32'd1);
        check_read("t5_pred_rd", 4'd0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, NOT_TAKEN);
        check("t5_pvalid", 32'(o_pred_valid), 32'd1);
        check("t5_pred", 32'(o_pred), 32'(NOT_TAKEN));
        check_write("t5_pend_wr", 4'd4, 2'b10);
        drive(1'b0, 32'h0, 1'b0, 32'h0, NOT_TAKEN);
        check("t5_done_en", 32'(mem_en), 32'd0);
        check("t5_pht4", 32'(pht[4]), 32'd2);

        // 6. Reset while a write is pending in WR_PEND.
        drive(1'b0, 32'h0, 1'b1, 32'h54, TAKEN);
        drive(1'b0, 32'h0, 1'b0, 32'h0, NOT_TAKEN);
        check_read("t6_upd_rd", 4'd5);
        drive(1'b1, 32'h40, 1'b0, 32'h0, NOT_TAKEN);
        check_read("t6_pred_rd", 4'd0);
        @(negedge clk);
        rst = 1'b1;
        i_req_valid = 1'b0;
        #1;
        check_all_zero("t6_rst");
        drive(1'b0, 32'h0, 1'b0, 32'h0, NOT_TAKEN);
        check_all_zero("t6_rst2");
        check("t6_pht5_unwritten", 32'(pht[5]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        i_req_valid = 1'b1;
        i_req_pc = 32'h40;
        #1;
        init_sweep("t6_sweep");
        drive(1'b0, 32'h0, 1'b0, 32'h0, NOT_TAKEN);
        check("t6_fifo_empty_en", 32'(mem_en), 32'd0);
        check("t6_fb_rdy", 32'(o_fb_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
